// File: rtl/ram_responder_pkg.sv
// Shared types and constants for the RAM responder and anything that
// talks to it (state encoding, counter width, default geometry).
package ram_responder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int CntWidth     = 4;
   localparam int DefDataWidth = 32;
   localparam int DefAddrWidth = 32;
   localparam int DefDepth     = 1024;

endpackage

// File: rtl/ram_word_array.sv
// Single-port synchronous word array with registered read data.
// Read-before-write on a combined access; contents are never reset.
module ram_word_array #(
   parameter int DataWidth = 32,
   parameter int Depth     = 1024,
   parameter int IdxWidth  = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic                 we,
   input  logic [IdxWidth-1:0]  addr,
   input  logic [DataWidth-1:0] wdata,
   output logic [DataWidth-1:0] rdata
);

   logic [DataWidth-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: latches a processor request, waits WaitStates
// cycles, performs one array access and completes with the MFC handshake.
module ram_responder
   import ram_responder_pkg::*;
#(
   parameter int DataWidth  = DefDataWidth,
   parameter int AddrWidth  = DefAddrWidth,
   parameter int Depth      = DefDepth,
   parameter int WaitStates = 2
) (
   input  logic                 Clock,
   input  logic                 Reset_L,
   input  logic                 RAM1_Enable,
   input  logic                 RAM1_Read_H_Write_L,
   input  logic [AddrWidth-1:0] RAM1_Address,
   input  logic [DataWidth-1:0] RAM1_Data_In,
   output logic [DataWidth-1:0] RAM1_Data_Out,
   output logic                 RAM1_MFC,
   output logic                 RAM1_Busy,
   output logic                 RAM1_Addr_Error,
   output state_t               fsm_state
);

   // Handshake: RAM1_Enable is the request valid, held until RAM1_MFC is
   // seen; RAM1_MFC stays high until Enable=0 is sampled in DONE, and a new
   // request is only accepted after that low phase has returned us to IDLE.

   localparam int                   IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [AddrWidth:0]   DepthExt = (AddrWidth + 1)'(Depth);
   localparam logic [CntWidth-1:0]  WaitLoad = CntWidth'(WaitStates);
   localparam logic [CntWidth-1:0]  CntOne   = CntWidth'(1);

   state_t               state, state_next;
   logic [CntWidth-1:0]  cnt;
   logic [AddrWidth-1:0] addr_q;
   logic                 read_q;
   logic [DataWidth-1:0] wdata_q;
   logic                 err_q;
   logic                 mfc_q;
   logic [DataWidth-1:0] dout_q;
   logic                 out_of_range;
   logic                 arr_en;
   logic                 arr_we;
   logic [DataWidth-1:0] arr_rdata;

   // Full-width compare: an address like 0x400 or 0x80000005 must not alias.
   assign out_of_range = {1'b0, addr_q} >= DepthExt;

   always_ff @(posedge Clock) begin
      if (!Reset_L) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      arr_en     = 1'b0;
      arr_we     = 1'b0;
      case (state)
         IDLE: begin
            if (RAM1_Enable) state_next = (WaitStates == 0) ? ACCESS : WAIT;
         end
         WAIT: begin
            if (cnt == CntOne) state_next = ACCESS;
         end
         ACCESS: begin
            arr_en     = !out_of_range;
            arr_we     = !read_q && !out_of_range;
            state_next = DONE;
         end
         DONE: begin
            // MFC must have been visible for a cycle before we may leave.
            if (mfc_q && !RAM1_Enable) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset_L) begin
         cnt     <= '0;
         addr_q  <= '0;
         read_q  <= 1'b1;
         wdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (RAM1_Enable) begin
                  addr_q  <= RAM1_Address;
                  read_q  <= RAM1_Read_H_Write_L;
                  wdata_q <= RAM1_Data_In;
                  cnt     <= WaitLoad;
               end
            end
            WAIT:    cnt <= cnt - CntOne;
            default: ;
         endcase
      end
   end

   // First DONE cycle picks up the registered array data and raises MFC.
   always_ff @(posedge Clock) begin
      if (!Reset_L) begin
         mfc_q  <= 1'b0;
         err_q  <= 1'b0;
         dout_q <= '0;
      end else begin
         if (state == ACCESS) err_q <= out_of_range;
         if (state == DONE && !mfc_q) begin
            mfc_q <= 1'b1;
            if (read_q) dout_q <= err_q ? '0 : arr_rdata;
         end else if (state == DONE && !RAM1_Enable) begin
            mfc_q <= 1'b0;
         end
      end
   end

   ram_word_array #(
      .DataWidth (DataWidth),
      .Depth     (Depth),
      .IdxWidth  (IdxWidth)
   ) u_array (
      .clk   (Clock),
      .en    (arr_en),
      .we    (arr_we),
      .addr  (addr_q[IdxWidth-1:0]),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   assign RAM1_Data_Out   = dout_q;
   assign RAM1_MFC        = mfc_q;
   assign RAM1_Busy       = (state != IDLE);
   assign RAM1_Addr_Error = mfc_q & err_q;
   assign fsm_state       = state;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: three instances with WaitStates of
// 2, 0 and 15 share clock and reset; each scenario task checks inline.
module tb_ram_responder;
   import ram_responder_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        en   [3];
   logic        rw   [3];
   logic [31:0] addr [3];
   logic [31:0] din  [3];
   logic [31:0] dout [3];
   logic        mfc  [3];
   logic        busy [3];
   logic        aerr [3];
   state_t      st   [3];
   int          acc_cnt [3] = '{0, 0, 0};
   int          n_checks = 0;
   int          n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ram_responder #(.WaitStates(2)) dut_ws2 (
      .Clock(clk), .Reset_L(rst_n), .RAM1_Enable(en[0]), .RAM1_Read_H_Write_L(rw[0]),
      .RAM1_Address(addr[0]), .RAM1_Data_In(din[0]), .RAM1_Data_Out(dout[0]),
      .RAM1_MFC(mfc[0]), .RAM1_Busy(busy[0]), .RAM1_Addr_Error(aerr[0]), .fsm_state(st[0]));

   ram_responder #(.WaitStates(0)) dut_ws0 (
      .Clock(clk), .Reset_L(rst_n), .RAM1_Enable(en[1]), .RAM1_Read_H_Write_L(rw[1]),
      .RAM1_Address(addr[1]), .RAM1_Data_In(din[1]), .RAM1_Data_Out(dout[1]),
      .RAM1_MFC(mfc[1]), .RAM1_Busy(busy[1]), .RAM1_Addr_Error(aerr[1]), .fsm_state(st[1]));

   ram_responder #(.WaitStates(15)) dut_ws15 (
      .Clock(clk), .Reset_L(rst_n), .RAM1_Enable(en[2]), .RAM1_Read_H_Write_L(rw[2]),
      .RAM1_Address(addr[2]), .RAM1_Data_In(din[2]), .RAM1_Data_Out(dout[2]),
      .RAM1_MFC(mfc[2]), .RAM1_Busy(busy[2]), .RAM1_Addr_Error(aerr[2]), .fsm_state(st[2]));

   // Counts cycles spent in ACCESS, i.e. array accesses performed.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (st[k] == ACCESS) acc_cnt[k] = acc_cnt[k] + 1;
      end
   end

   function automatic int ws_of(input int k);
      case (k)
         0:       return 2;
         1:       return 0;
         default: return 15;
      endcase
   endfunction

   // Drivers: callers are always positioned just after a falling edge.
   task automatic start_req(input int k, input logic rd, input logic [31:0] a,
                            input logic [31:0] d);
      rw[k]   = rd;
      addr[k] = a;
      din[k]  = d;
      en[k]   = 1'b1;
   endtask

   // Returns the index of the rising edge after which MFC was seen, -1 on timeout.
   task automatic wait_mfc(input int k, input bit scramble, output int edges);
      edges = -1;
      for (int e = 0; e < 40; e++) begin
         if (edges < 0) begin
            @(posedge clk);
            @(negedge clk);
            if (mfc[k]) edges = e;
            else if (scramble && e == 0) begin
               addr[k] = ~addr[k];
               din[k]  = ~din[k];
               rw[k]   = ~rw[k];
            end
         end
      end
   endtask

   task automatic end_req(input int k);
      en[k] = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_access(input int k, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, output int edges,
                            output logic [31:0] data, output logic err);
      start_req(k, rd, a, d);
      wait_mfc(k, 1'b0, edges);
      data = dout[k];
      err  = aerr[k];
      end_req(k);
   endtask

   task automatic test_reset;
      int base;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         en[k] = 1'b1; rw[k] = 1'b1; addr[k] = 32'd5; din[k] = 32'd0;
      end
      base = acc_cnt[0] + acc_cnt[1] + acc_cnt[2];
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (mfc[k] !== 1'b0) begin
            n_fail++; $display("FAIL reset_mfc[%0d]: got %b expected 0", k, mfc[k]);
         end
         n_checks++;
         if (busy[k] !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]);
         end
         n_checks++;
         if (dout[k] !== 32'h0) begin
            n_fail++; $display("FAIL reset_dout[%0d]: got %h expected 00000000", k, dout[k]);
         end
         n_checks++;
         if (aerr[k] !== 1'b0) begin
            n_fail++; $display("FAIL reset_aerr[%0d]: got %b expected 0", k, aerr[k]);
         end
      end
      n_checks++;
      if (acc_cnt[0] + acc_cnt[1] + acc_cnt[2] != base) begin
         n_fail++; $display("FAIL reset_no_access: got %0d accesses expected 0",
                            acc_cnt[0] + acc_cnt[1] + acc_cnt[2] - base);
      end
      for (int k = 0; k < 3; k++) en[k] = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_write_read;
      int          edges;
      logic [31:0] data;
      logic        err;
      do_access(0, 1'b0, 32'd0, 32'hA5A5_A5A5, edges, data, err);
      do_access(0, 1'b0, 32'd3, 32'h1111_1111, edges, data, err);
      start_req(0, 1'b0, 32'd5, 32'hDEAD_BEEF);
      wait_mfc(0, 1'b0, edges);
      n_checks++;
      if (edges !== 4) begin
         n_fail++; $display("FAIL wr_latency: got edge %0d expected edge 4", edges);
      end
      n_checks++;
      if (aerr[0] !== 1'b0) begin
         n_fail++; $display("FAIL wr_aerr: got %b expected 0", aerr[0]);
      end
      end_req(0);
      n_checks++;
      if (mfc[0] !== 1'b0 || busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL wr_mfc_fall: got mfc=%b busy=%b expected 0/0", mfc[0], busy[0]);
      end
      start_req(0, 1'b1, 32'd5, 32'h0);
      wait_mfc(0, 1'b0, edges);
      n_checks++;
      if (edges !== 4) begin
         n_fail++; $display("FAIL rd_latency: got edge %0d expected edge 4", edges);
      end
      n_checks++;
      if (dout[0] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL rd_data: got %h expected deadbeef", dout[0]);
      end
      end_req(0);
   endtask

   task automatic test_hold;
      int edges;
      int base;
      int bad;
      base = acc_cnt[0];
      bad  = 0;
      start_req(0, 1'b1, 32'd5, 32'h0);
      wait_mfc(0, 1'b0, edges);
      n_checks++;
      if (edges !== 4) begin
         n_fail++; $display("FAIL hold_latency: got edge %0d expected edge 4", edges);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (mfc[0] !== 1'b1 || busy[0] !== 1'b1 || st[0] !== DONE) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL hold_mfc_busy: got %0d bad cycles expected 0", bad);
      end
      n_checks++;
      if (dout[0] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL hold_data: got %h expected deadbeef", dout[0]);
      end
      end_req(0);
      n_checks++;
      if (busy[0] !== 1'b0 || st[0] !== IDLE || mfc[0] !== 1'b0) begin
         n_fail++; $display("FAIL hold_release: got busy=%b mfc=%b state=%0d expected 0/0/IDLE",
                            busy[0], mfc[0], st[0]);
      end
      n_checks++;
      if (acc_cnt[0] - base != 1) begin
         n_fail++; $display("FAIL hold_one_access: got %0d accesses expected 1", acc_cnt[0] - base);
      end
   endtask

   task automatic test_out_of_range;
      int          edges;
      logic [31:0] data;
      logic        err;
      do_access(0, 1'b1, 32'd1024, 32'h0, edges, data, err);
      n_checks++;
      if (edges !== 4 || err !== 1'b1 || data !== 32'h0) begin
         n_fail++; $display("FAIL oor_read_1024: got edge=%0d err=%b data=%h expected 4/1/00000000",
                            edges, err, data);
      end
      do_access(0, 1'b0, 32'h0000_0400, 32'h1234_5678, edges, data, err);
      n_checks++;
      if (err !== 1'b1) begin
         n_fail++; $display("FAIL oor_write_err: got %b expected 1", err);
      end
      do_access(0, 1'b1, 32'd0, 32'h0, edges, data, err);
      n_checks++;
      if (data !== 32'hA5A5_A5A5 || err !== 1'b0) begin
         n_fail++; $display("FAIL oor_mem0_intact: got %h err=%b expected a5a5a5a5 err=0", data, err);
      end
      do_access(0, 1'b1, 32'h8000_0005, 32'h0, edges, data, err);
      n_checks++;
      if (data !== 32'h0 || err !== 1'b1) begin
         n_fail++; $display("FAIL oor_high_bits: got %h err=%b expected 00000000 err=1", data, err);
      end
      do_access(0, 1'b0, 32'd1023, 32'h0BAD_CAFE, edges, data, err);
      do_access(0, 1'b1, 32'd1023, 32'h0, edges, data, err);
      n_checks++;
      if (data !== 32'h0BAD_CAFE || err !== 1'b0) begin
         n_fail++; $display("FAIL last_word: got %h err=%b expected 0badcafe err=0", data, err);
      end
   endtask

   task automatic test_reset_during_wait;
      int          edges;
      int          rises;
      logic [31:0] data;
      logic        err;
      rises = 0;
      start_req(0, 1'b0, 32'd3, 32'hCAFE_F00D);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (st[0] !== WAIT) begin
         n_fail++; $display("FAIL rst_wait_state: got %0d expected WAIT", st[0]);
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      en[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (mfc[0] === 1'b1) rises++;
      end
      n_checks++;
      if (rises != 0 || st[0] !== IDLE) begin
         n_fail++; $display("FAIL rst_wait_abandon: got %0d mfc cycles state=%0d expected 0/IDLE",
                            rises, st[0]);
      end
      do_access(0, 1'b1, 32'd3, 32'h0, edges, data, err);
      n_checks++;
      if (data !== 32'h1111_1111) begin
         n_fail++; $display("FAIL rst_wait_no_write: got %h expected 11111111", data);
      end
   endtask

   task automatic test_protocol_violation;
      int          pulses;
      int          first;
      logic [31:0] seen;
      pulses = 0;
      first  = -1;
      seen   = 32'h0;
      start_req(0, 1'b1, 32'd5, 32'h0);
      @(posedge clk);
      @(negedge clk);
      en[0] = 1'b0;
      for (int e = 1; e < 12; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (mfc[0] === 1'b1) begin
            pulses++;
            if (first < 0) begin
               first = e;
               seen  = dout[0];
            end
         end
      end
      n_checks++;
      if (pulses != 1 || first != 4) begin
         n_fail++; $display("FAIL early_drop_pulse: got %0d cycles at edge %0d expected 1 at edge 4",
                            pulses, first);
      end
      n_checks++;
      if (seen !== 32'hDEAD_BEEF || st[0] !== IDLE) begin
         n_fail++; $display("FAIL early_drop_done: got data=%h state=%0d expected deadbeef/IDLE",
                            seen, st[0]);
      end
   endtask

   task automatic test_scramble(input int k);
      int          edges;
      logic [31:0] data;
      logic        err;
      do_access(k, 1'b0, 32'd9, 32'h0000_0099, edges, data, err);
      start_req(k, 1'b0, 32'd7, 32'h55AA_0001);
      wait_mfc(k, 1'b1, edges);
      n_checks++;
      if (edges !== ws_of(k) + 2 || aerr[k] !== 1'b0) begin
         n_fail++; $display("FAIL scr_write[%0d]: got edge=%0d err=%b expected %0d/0",
                            k, edges, aerr[k], ws_of(k) + 2);
      end
      end_req(k);
      start_req(k, 1'b1, 32'd7, 32'h0);
      wait_mfc(k, 1'b1, edges);
      n_checks++;
      if (edges !== ws_of(k) + 2 || dout[k] !== 32'h55AA_0001 || aerr[k] !== 1'b0) begin
         n_fail++; $display("FAIL scr_read[%0d]: got edge=%0d data=%h err=%b expected %0d/55aa0001/0",
                            k, edges, dout[k], aerr[k], ws_of(k) + 2);
      end
      end_req(k);
      do_access(k, 1'b1, 32'd9, 32'h0, edges, data, err);
      n_checks++;
      if (data !== 32'h0000_0099) begin
         n_fail++; $display("FAIL scr_neighbour[%0d]: got %h expected 00000099", k, data);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_hold();
      test_out_of_range();
      test_reset_during_wait();
      test_protocol_violation();
      test_scramble(1);
      test_scramble(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the processor's RAM port. It accepts a word-addressed read or write request from the processor's memory stage and performs it on an internal word array after a programmable number of wait states. It signals completion with the MFC (memory function complete) four-phase handshake that the processor stalls on. It sits between the processor's RAM1_* outputs and RAM1_Data_Out/RAM1_MFC inputs and replaces the ideal single-cycle RAM model.

## Interface
- DataWidth, 32: word width.
- AddrWidth, 32: width of the processor address bus (word address).
- Depth, 1024: number of implemented words; valid addresses are 0..Depth-1.
- WaitStates, 2: extra cycles inserted before each access; legal range 0..15.

Ports:
- Clock  in  1  system clock. One clock domain; all state changes on the rising edge.
- Reset_L  in  1  reset. Synchronous, active-low.
- RAM1_Enable  in  1  request strobe from the processor. Held high until MFC is seen.
- RAM1_Read_H_Write_L  in  1  access direction: 1 = read, 0 = write.
- RAM1_Address  in  AddrWidth  word address.
- RAM1_Data_In  in  DataWidth  write data.
- RAM1_Data_Out  out  DataWidth  read data. Valid while RAM1_MFC=1 after a read.
- RAM1_MFC  out  1  memory function complete.
- RAM1_Busy  out  1  high whenever the FSM is not in IDLE.
- RAM1_Addr_Error  out  1  the completed access addressed a word at or above Depth. Qualified by MFC.

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - If RAM1_Enable=1, latch address, direction and write data.
  - Load wait counter = WaitStates.
  - Go to WAIT, or directly to ACCESS if WaitStates=0.
- WAIT:
  - Decrement the counter each cycle.
  - Go to ACCESS on the cycle the counter reads 1.
  - Bus inputs are ignored; only the latched values are used.
- ACCESS (one cycle):
  - Read: RAM1_Data_Out <= mem[addr].
  - Write: mem[addr] <= data.
  - If addr >= Depth: no array access, RAM1_Data_Out <= 0, error bit set.
  - Go to DONE.
- DONE:
  - RAM1_MFC=1.
  - RAM1_Addr_Error reflects the error bit.
  - Stay in DONE while RAM1_Enable=1. When RAM1_Enable=0, go to IDLE and MFC drops on that edge.
- RAM1_Enable dropping before MFC is a protocol violation. The access still completes, MFC pulses for exactly one cycle, then the FSM returns to IDLE.
- RAM1_Data_Out holds its last read value until the next read completes. Writes do not disturb it.
- The address comparison uses the full AddrWidth bits; no wrap-around, and upper bits are not truncated.

## Timing
- Reset (Reset_L=0 at an edge):
  - State = IDLE; RAM1_MFC=0, RAM1_Busy=0, RAM1_Addr_Error=0, RAM1_Data_Out=0.
  - Array contents are not cleared.
  - Reset asserted during WAIT abandons the access; a pending write is not performed.
  - Reset asserted in ACCESS or DONE: a write already committed in ACCESS remains.
- Request latency: the edge that samples RAM1_Enable=1 in IDLE is edge 0; RAM1_MFC goes high after edge WaitStates+2.
- MFC fall: the first edge at which RAM1_Enable=0 is sampled in DONE.
- Minimum turnaround: a new request can be sampled on the edge after the FSM returns to IDLE. One access per WaitStates+4 cycles at best.
- Simultaneous events: RAM1_Enable high in DONE never starts a second access. A new request requires the low phase.

## Structure
- Package ram_responder_pkg holds:
  - the state enum (IDLE, WAIT, ACCESS, DONE);
  - the wait-counter width constant (4 bits);
  - the default DataWidth/Depth constants, shared with the processor bench.
- Sub-module ram_word_array: single-port synchronous array with write enable, address and data-in. It exposes registered read data and is the inference target for on-chip RAM.
- The FSM, wait counter, request latches and error check live in ram_responder.

## Test plan
- Reset: hold Reset_L=0 for 2 cycles with RAM1_Enable=1 -> RAM1_MFC=0, RAM1_Busy=0, RAM1_Data_Out=0x00000000, and no access occurs.
- Write/read, WaitStates=2:
  - Write 0xDEADBEEF to address 5 -> MFC high after edge 4; drop Enable -> MFC low the next edge.
  - Read address 5 -> RAM1_Data_Out=0xDEADBEEF with MFC.
- Hold Enable high for 10 cycles after MFC -> MFC stays 1, exactly one access is performed, Busy=1 throughout. Enable low -> IDLE, Busy=0.
- Out-of-range: read address 1024 (Depth=1024) -> MFC with RAM1_Addr_Error=1, Data_Out=0. Write 0x12345678 to 0x00000400 -> mem[0] is unchanged when read back.
- Reset during WAIT of a write of 0xCAFEF00D to address 3 -> MFC never rises; a subsequent read of address 3 returns the prior value.
- Changing RAM1_Address/Data_In during WAIT, with WaitStates=0 and WaitStates=15 -> only the latched values are used; MFC arrives after edge 2 and after edge 17 respectively.
